fmap_out_reader: RTL and testbench
==================================

FMAP_OUT_READER -- requirements
Module: fmap_out_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of one feature-map element.
REQ-002 SHALL have parameter IDX_W, default 3: index width; map is DIM x DIM with DIM = 2**IDX_W (default 8x8).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (rst=0 resets).
REQ-005 start  input  1  frame request; sampled only in IDLE.
REQ-006 rd_en  output  1  buffer read strobe.
REQ-007 rd_addr  output  2*IDX_W  buffer read address = {j,i}.
REQ-008 rd_data  input  DATA_W  buffer data; valid the cycle after the rd_en cycle (1-cycle latency, no stall).
REQ-009 m_data  output  DATA_W  streamed element.
REQ-010 m_i, m_j  output  IDX_W each  column/row index of m_data.
REQ-011 m_valid  output  1  m_data/m_i/m_j/m_last valid.
REQ-012 m_ready  input  1  downstream accept; beat transfers when m_valid & m_ready at an edge.
REQ-013 m_last  output  1  high with the final element (i=DIM-1, j=DIM-1).
REQ-014 busy  output  1  high in RUN and DRAIN.
REQ-015 done  output  1  one-cycle pulse, frame complete.

Function
REQ-016 States: IDLE, RUN, DRAIN; IDLE->RUN on start=1; RUN->DRAIN at edge issuing final read; DRAIN->IDLE at edge transferring final beat.
REQ-017 Read order: i increments first 0..DIM-1; at i=DIM-1, i wraps to 0 and j increments; exactly DIM*DIM reads per frame, no wrap past (DIM-1,DIM-1).
REQ-018 rd_en high only in RUN, one read per cycle max, first read address 0 in cycle after start edge.
REQ-019 Output buffer: 2-entry FIFO, first-word-fall-through; rd_data written with its i/j tag in cycle after its rd_en.
REQ-020 Credit rule: rd_en=1 only if occupancy + in-flight - (m_valid & m_ready) < 2; buffer never overflows, no element dropped or duplicated.
REQ-021 With m_ready held 1: first m_valid in cycle after second edge following start edge; then one beat per cycle, DIM*DIM consecutive beats.
REQ-022 While m_valid=1 and m_ready=0, m_data, m_i, m_j, m_last SHALL hold stable.
REQ-023 m_valid=0 whenever buffer empty; m_last=1 only on beat (DIM-1,DIM-1).
REQ-024 done=1 in cycle after final-beat edge; busy=0 in same cycle.
REQ-025 start ignored while busy=1; start=1 in done cycle begins a new frame (state already IDLE).
REQ-026 rd_data not sampled when no read was issued the previous cycle.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, counters 0, buffer empty, in-flight cleared; rd_en, rd_addr, m_data, m_i, m_j, m_valid, m_last, busy, done all 0.
REQ-028 Reset mid-frame discards all pending data; next start restarts at address 0.
REQ-029 Read data returning in the first cycle after reset deassertion SHALL be ignored.

Verification
REQ-030 Reset: drive rst=0 mid-cycle -> all outputs 0 before next edge; hold 3 cycles, release -> outputs stay 0, state IDLE.
REQ-031 Full-rate: buffer[a]=a, m_ready=1, one start pulse -> 64 beats m_data 0..63 in consecutive cycles, (m_i,m_j) = (0,0),(1,0)..(7,0),(0,1)..(7,7), m_last only on beat 63, done one cycle later.
REQ-032 Backpressure: m_ready pattern 1,0,1,0 then 0 for 5 cycles, repeat -> all 64 values in order exactly once, outputs stable during stalls, never more than 2 buffered + in-flight.
REQ-033 Start handling: start pulses at beats 10 and 40 -> ignored, single 64-beat frame; start in done cycle -> second frame begins at address 0 without gap.
REQ-034 Mid-frame reset: rst=0 after beat 20 with read in flight -> immediate clear, no further beats; new start -> beats 0..63 from address 0.
REQ-035 Parameters: DATA_W=8, IDX_W=2 -> 16 beats, m_last on (3,3), rd_addr 4 bits, data exact.

Source files
------------

// File: rtl/fmap_out_reader.sv
// Streams a DIM x DIM feature map out of a 1-cycle-latency buffer in row-major
// order (i fastest), through a 2-entry first-word-fall-through output buffer.
module fmap_out_reader #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 rd_en,
  output logic [2*IDX_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]    rd_data,
  output logic [DATA_W-1:0]    m_data,
  output logic [IDX_W-1:0]     m_i,
  output logic [IDX_W-1:0]     m_j,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_RUN   = 2'd1;
  localparam logic [1:0]       S_DRAIN = 2'd2;
  localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_i;
  logic [IDX_W-1:0]  r_j;
  logic              r_inflight;
  logic [IDX_W-1:0]  r_tag_i;
  logic [IDX_W-1:0]  r_tag_j;
  logic              r_done;

  logic [DATA_W-1:0] r_hd_data;
  logic [IDX_W-1:0]  r_hd_i;
  logic [IDX_W-1:0]  r_hd_j;
  logic              r_hd_last;
  logic              r_hd_valid;
  logic [DATA_W-1:0] r_sk_data;
  logic [IDX_W-1:0]  r_sk_i;
  logic [IDX_W-1:0]  r_sk_j;
  logic              r_sk_last;
  logic              r_sk_valid;

  logic              w_pop;
  logic              w_push;
  logic              w_rd_en;
  logic              w_final_rd;
  logic              w_in_last;
  logic [2:0]        w_pending;

  function automatic logic is_corner(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] j);
    return (i == IDX_MAX) && (j == IDX_MAX);
  endfunction

  assign w_pop      = r_hd_valid & m_ready;
  assign w_push     = r_inflight;
  assign w_pending  = {2'b00, r_hd_valid} + {2'b00, r_sk_valid} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_in_last  = is_corner(r_tag_i, r_tag_j);
  assign w_final_rd = w_rd_en & is_corner(r_i, r_j);

  // Issue a read only while running and only if every outstanding element still has a slot.
  always_comb begin
    w_rd_en = 1'b0;
    if ((r_state == S_RUN) && (w_pending < 3'd2)) begin
      w_rd_en = 1'b1;
    end else begin
      w_rd_en = 1'b0;
    end
  end

  // Frame sequencing: state, read address counters, in-flight tag and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_inflight <= 1'b0;
      r_tag_i    <= '0;
      r_tag_j    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      r_done     <= 1'b0;
      if (w_rd_en) begin
        r_tag_i <= r_i;
        r_tag_j <= r_j;
        r_i     <= r_i + IDX_ONE;
        if (r_i == IDX_MAX) begin
          r_j <= r_j + IDX_ONE;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Counters wrap to (0,0) on the final read, ready for the next frame.
          if (w_final_rd) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && r_hd_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output buffer: head register drives the stream, skid register holds the second entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hd_data  <= '0;
      r_hd_i     <= '0;
      r_hd_j     <= '0;
      r_hd_last  <= 1'b0;
      r_hd_valid <= 1'b0;
      r_sk_data  <= '0;
      r_sk_i     <= '0;
      r_sk_j     <= '0;
      r_sk_last  <= 1'b0;
      r_sk_valid <= 1'b0;
    end else if (w_pop) begin
      if (r_sk_valid) begin
        r_hd_data <= r_sk_data;
        r_hd_i    <= r_sk_i;
        r_hd_j    <= r_sk_j;
        r_hd_last <= r_sk_last;
        if (w_push) begin
          r_sk_data <= rd_data;
          r_sk_i    <= r_tag_i;
          r_sk_j    <= r_tag_j;
          r_sk_last <= w_in_last;
        end else begin
          r_sk_valid <= 1'b0;
        end
      end else if (w_push) begin
        r_hd_data <= rd_data;
        r_hd_i    <= r_tag_i;
        r_hd_j    <= r_tag_j;
        r_hd_last <= w_in_last;
      end else begin
        r_hd_valid <= 1'b0;
      end
    end else if (w_push) begin
      if (r_hd_valid) begin
        r_sk_data  <= rd_data;
        r_sk_i     <= r_tag_i;
        r_sk_j     <= r_tag_j;
        r_sk_last  <= w_in_last;
        r_sk_valid <= 1'b1;
      end else begin
        r_hd_data  <= rd_data;
        r_hd_i     <= r_tag_i;
        r_hd_j     <= r_tag_j;
        r_hd_last  <= w_in_last;
        r_hd_valid <= 1'b1;
      end
    end
  end

  assign rd_en   = w_rd_en;
  assign rd_addr = {r_j, r_i};
  assign m_data  = r_hd_data;
  assign m_i     = r_hd_i;
  assign m_j     = r_hd_j;
  assign m_last  = r_hd_last;
  assign m_valid = r_hd_valid;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;

endmodule

// File: tb/tb_fmap_out_reader.sv
// Bench for fmap_out_reader: random buffer contents and downstream readiness,
// checked against a frame-level model of reads issued and beats delivered.
module tb_fmap_out_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] m_data;
  logic [2:0]  m_i;
  logic [2:0]  m_j;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic        busy;
  logic        done;

  logic        s_start = 1'b0;
  logic        s_rd_en;
  logic [3:0]  s_rd_addr;
  logic [7:0]  s_rd_data;
  logic [7:0]  s_m_data;
  logic [1:0]  s_m_i;
  logic [1:0]  s_m_j;
  logic        s_m_valid;
  logic        s_m_ready = 1'b1;
  logic        s_m_last;
  logic        s_busy;
  logic        s_done;

  logic [15:0] mem [64];
  logic [7:0]  smem [16];

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int rmode = 0;
  int pidx = 0;
  int pat [9] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};

  // model state for the 8x8 instance
  bit mb = 1'b0;
  bit md = 1'b0;
  bit last_rd = 1'b0;
  bit prev_stall = 1'b0;
  logic [22:0] prev_vec = '0;
  int reads = 0;
  int beats = 0;
  int nframes = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  // model state for the 4x4 instance
  int sb = 0;
  int sreads = 0;
  int sframes = 0;

  fmap_out_reader #(.DATA_W(16), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .m_data(m_data), .m_i(m_i), .m_j(m_j), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  fmap_out_reader #(.DATA_W(8), .IDX_W(2)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .m_data(s_m_data), .m_i(s_m_i), .m_j(s_m_j), .m_valid(s_m_valid),
    .m_ready(s_m_ready), .m_last(s_m_last), .busy(s_busy), .done(s_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // buffer model: 1-cycle read latency, garbage on cycles without a read
  always @(posedge clk) begin
    rd_data   <= rd_en ? mem[rd_addr] : 16'($urandom);
    s_rd_data <= s_rd_en ? smem[s_rd_addr] : 8'($urandom);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // frame model for the 8x8 instance: everything seen now transfers at the next edge
  always @(negedge clk) begin
    if (!rst) begin
      mb = 1'b0; md = 1'b0; reads = 0; beats = 0; last_rd = 1'b0; prev_stall = 1'b0;
    end else begin
      bit was_idle;
      logic [22:0] cur;
      logic [22:0] expv;
      was_idle = !mb;
      cur  = {m_data, m_i, m_j, m_last};
      expv = {mem[beats % 64], 3'(beats % 8), 3'(beats / 8), 1'(beats == 63)};
      chk("busy", 64'(busy), 64'(mb));
      chk("done", 64'(done), 64'(md));
      md = 1'b0;
      chk("credit", 64'((reads - beats) <= 2), 64'd1);
      if (prev_stall) chk("stall_hold", 64'(cur), 64'(prev_vec));
      if (m_valid) begin
        chk("m_avail", 64'(beats < reads), 64'd1);
        chk("m_beat", 64'(cur), 64'(expv));
      end
      if (rd_en) begin
        chk("rd_gate", 64'({mb, reads < 64}), 64'd3);
        chk("rd_addr", 64'(rd_addr), 64'(reads));
        reads++;
      end
      prev_stall = m_valid && !m_ready;
      prev_vec   = cur;
      last_rd    = rd_en;
      if (m_valid && m_ready) begin
        if (beats == 0) first_cyc = cyc;
        if (beats == 63) last_cyc = cyc;
        beats++;
        if (beats == 64) begin
          md = 1'b1; mb = 1'b0; reads = 0; beats = 0; nframes++;
        end
      end
      if (was_idle && start) mb = 1'b1;
    end
  end

  // beat model for the 4x4 instance
  always @(negedge clk) begin
    if (!rst) begin
      sb = 0; sreads = 0;
    end else begin
      if (s_m_valid)
        chk("s_beat", 64'({s_m_data, s_m_i, s_m_j, s_m_last}),
            64'({smem[sb], 2'(sb % 4), 2'(sb / 4), 1'(sb == 15)}));
      if (s_rd_en) begin
        chk("s_rd_addr", 64'(s_rd_addr), 64'(sreads));
        sreads++;
      end
      if (s_m_valid && s_m_ready) begin
        sb++;
        if (sb == 16) begin
          sb = 0; sreads = 0; sframes++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: begin m_ready = 1'(pat[pidx]); pidx = (pidx + 1) % 9; end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    s_m_ready = 1'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin step(); n++; end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'({rd_en, rd_addr, m_data, m_i, m_j, m_valid, m_last, busy, done}), 64'd0);
  endtask

  initial begin
    int n;
    int start_cyc;
    for (int a = 0; a < 64; a++) mem[a] = 16'(a);
    for (int a = 0; a < 16; a++) smem[a] = 8'($urandom);

    // asynchronous reset asserted mid-cycle, held 3 cycles, released
    #7 rst = 1'b0;
    #1 chk_zero("reset_async");
    repeat (3) step();
    rst = 1'b1;
    #1 chk_zero("reset_release");
    step();
    chk_zero("reset_idle");

    // full-rate frame with buffer[a] = a
    rmode = 0;
    start = 1'b1; start_cyc = cyc;
    step();
    start = 1'b0;
    wait_done("f1_done", 200);
    chk("f1_first_lat", 64'(first_cyc), 64'(start_cyc + 3));
    chk("f1_consecutive", 64'(last_cyc - first_cyc), 64'd63);
    chk("f1_frames", 64'(nframes), 64'd1);

    // start in the done cycle, then backpressure pattern
    for (int a = 0; a < 64; a++) mem[a] = 16'($urandom);
    rmode = 1; pidx = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("f2_no_gap", 64'({rd_en, rd_addr, busy}), 64'({1'b1, 6'd0, 1'b1}));
    wait_done("f2_done", 1500);
    chk("f2_frames", 64'(nframes), 64'd2);

    // back-to-back again, random readiness, start pulses at beats 10 and 40
    for (int a = 0; a < 64; a++) mem[a] = 16'($urandom);
    rmode = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 1500) begin
      step(); n++;
      start = (beats == 10 || beats == 40);
    end
    start = 1'b0;
    chk("f3_done", 64'(done), 64'd1);
    chk("f3_frames", 64'(nframes), 64'd3);
    repeat (3) step();
    chk("f3_idle", 64'({busy, done, m_valid}), 64'd0);

    // mid-frame reset with a read in flight
    rmode = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(beats >= 21 && last_rd) && n < 200) begin step(); n++; end
    chk("mid_reach", 64'(beats >= 21 && last_rd), 64'd1);
    #2 rst = 1'b0;
    #1 chk_zero("mid_reset_async");
    repeat (3) step();
    chk_zero("mid_reset_hold");
    rst = 1'b1;
    #1 chk_zero("mid_reset_release");
    step();
    chk_zero("mid_reset_quiet");
    step();
    chk_zero("mid_reset_quiet2");

    // restart from address 0 after the reset
    for (int a = 0; a < 64; a++) mem[a] = 16'($urandom);
    rmode = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("f4_done", 1500);
    chk("f4_frames", 64'(nframes), 64'd4);

    // 4x4 instance with 8-bit data
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    n = 0;
    while (s_done !== 1'b1 && n < 500) begin step(); n++; end
    chk("s_done", 64'(s_done), 64'd1);
    chk("s_frames", 64'(sframes), 64'd1);
    step();
    chk("s_idle", 64'({s_busy, s_done, s_m_valid}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
